// File: rtl/smg_decode_module.sv
// smg_decode_module
// Recovers digit values from a multiplexed, active-low seven-segment display
// bus. The select and segment buses are synchronized, a select/segment pair
// must stay stable for STABLE_CYCLES clocks before it is captured, and each
// capture updates that digit's value, validity and decimal-point flag.
// A one-cycle Frame_Done pulse follows once all six digits have been captured.
// A one-cycle Code_Err pulse flags a capture whose segment pattern is not a
// recognized digit.
//
// Build option: define SMG_HEX_DECODE_EN to also decode the A..F patterns.
// Without it only 0..9 are legal.

module smg_decode_module #(
  parameter int STABLE_CYCLES = 16  // legal range 2..255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  SMG_Data,
  input  logic [5:0]  Scan_Sig,
  output logic [23:0] Digit_Data,
  output logic [5:0]  Digit_Valid,
  output logic [5:0]  Dp_Flags,
  output logic        Frame_Done,
  output logic        Code_Err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);

  // Two-flop synchronizer stages.
  logic [7:0] data_s1, data_s2;
  logic [5:0] sel_s1,  sel_s2;

  // Tracking state.
  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] lat_data;
  logic [5:0] lat_sel;
  logic       load_pair;
  logic       capture;

  // Frame bookkeeping.
  logic [5:0] frame_mask;

  // Returns {legal, value}; bit 7 is ignored so the decimal point never
  // changes the digit that is recognized.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case ({1'b1, seg})
      8'hc0: r = {1'b1, 4'h0};
      8'hf9: r = {1'b1, 4'h1};
      8'ha4: r = {1'b1, 4'h2};
      8'hb0: r = {1'b1, 4'h3};
      8'h99: r = {1'b1, 4'h4};
      8'h92: r = {1'b1, 4'h5};
      8'h82: r = {1'b1, 4'h6};
      8'hf8: r = {1'b1, 4'h7};
      8'h80: r = {1'b1, 4'h8};
      8'h90: r = {1'b1, 4'h9};
`ifdef SMG_HEX_DECODE_EN
      8'h88: r = {1'b1, 4'ha};
      8'h83: r = {1'b1, 4'hb};
      8'hc6: r = {1'b1, 4'hc};
      8'ha1: r = {1'b1, 4'hd};
      8'h86: r = {1'b1, 4'he};
      8'h8e: r = {1'b1, 4'hf};
`endif
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // True when exactly one select line is driven low.
  function automatic logic sel_one_low(input logic [5:0] sel);
    logic [5:0] inv;
    inv = ~sel;
    return (inv != 6'd0) && ((inv & (inv - 6'd1)) == 6'd0);
  endfunction

  // Digit index of a one-hot-low select.
  function automatic logic [2:0] sel_index(input logic [5:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic       sel_ok;
  logic       pair_same;
  logic [4:0] dec;
  logic [2:0] cap_idx;
  logic [5:0] cap_bit;
  logic [5:0] mask_merged;

  assign sel_ok      = sel_one_low(sel_s2);
  assign pair_same   = (sel_s2 == lat_sel) && (data_s2 == lat_data);
  assign dec         = decode_seg(lat_data[6:0]);
  assign cap_idx     = sel_index(lat_sel);
  assign cap_bit     = 6'd1 << cap_idx;
  assign mask_merged = frame_mask | cap_bit;

  // Synchronize the asynchronous display buses; idle values look like a
  // blanked display so reset release cannot start a capture.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes the chain two stages.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_s1 <= 8'hff;
      data_s2 <= 8'hff;
      sel_s1  <= 6'h3f;
      sel_s2  <= 6'h3f;
    end else begin
      data_s1 <= SMG_Data;
      data_s2 <= data_s1;
      sel_s1  <= Scan_Sig;
      sel_s2  <= sel_s1;
    end
  end

  // Next-state, stability counter and capture decision.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_pair  = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_ok) begin
          state_next = ST_TRACK;
          cnt_next   = 8'd1;
          load_pair  = 1'b1;
        end
      end
      ST_TRACK: begin
        if (pair_same) begin
          if (cnt == CNT_LAST) begin
            capture    = 1'b1;
            state_next = ST_HOLD;
            cnt_next   = CNT_FULL;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end else if (sel_ok) begin
          load_pair = 1'b1;
          cnt_next  = 8'd1;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end
      end
      ST_HOLD: begin
        if (!pair_same) begin
          if (sel_ok) begin
            state_next = ST_TRACK;
            load_pair  = 1'b1;
            cnt_next   = 8'd1;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // State register, stability counter and the latched pair under test.
  // NOTE: reset clears all control state so a TRACK in progress is abandoned
  // and the pair must be held for a full stable period after release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      lat_data <= 8'hff;
      lat_sel  <= 6'h3f;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_pair) begin
        lat_data <= data_s2;
        lat_sel  <= sel_s2;
      end
    end
  end

  // Capture path: digit outputs, frame mask and the two event pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Digit_Data  <= 24'h000000;
      Digit_Valid <= 6'h00;
      Dp_Flags    <= 6'h00;
      Frame_Done  <= 1'b0;
      Code_Err    <= 1'b0;
      frame_mask  <= 6'h00;
    end else begin
      Frame_Done <= 1'b0;
      Code_Err   <= 1'b0;
      if (capture) begin
        Dp_Flags[cap_idx] <= ~lat_data[7];
        if (dec[4]) begin
          Digit_Data[4*cap_idx +: 4] <= dec[3:0];
          Digit_Valid[cap_idx]       <= 1'b1;
        end else begin
          Digit_Valid[cap_idx] <= 1'b0;
          Code_Err             <= 1'b1;
        end
        if (mask_merged == 6'h3f) begin
          Frame_Done <= 1'b1;
          frame_mask <= 6'h00;
        end else begin
          frame_mask <= mask_merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_smg_decode_module.sv
// tb_smg_decode_module
// Directed bench for smg_decode_module with STABLE_CYCLES = 16. Inputs are
// driven and outputs sampled on the falling clock edge. Honors
// SMG_HEX_DECODE_EN when computing expected values.

module tb_smg_decode_module;

  localparam int S = 16;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  SMG_Data;
  logic [5:0]  Scan_Sig;
  logic [23:0] Digit_Data;
  logic [5:0]  Digit_Valid;
  logic [5:0]  Dp_Flags;
  logic        Frame_Done;
  logic        Code_Err;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  int ce_count = 0;

  smg_decode_module #(.STABLE_CYCLES(S)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SMG_Data   (SMG_Data),
    .Scan_Sig   (Scan_Sig),
    .Digit_Data (Digit_Data),
    .Digit_Valid(Digit_Valid),
    .Dp_Flags   (Dp_Flags),
    .Frame_Done (Frame_Done),
    .Code_Err   (Code_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse counters, sampled away from the active edge.
  always @(negedge CLK) begin
    if (Frame_Done === 1'b1) fd_count++;
    if (Code_Err === 1'b1)   ce_count++;
  end

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a pair at the falling edge and wait a number of falling edges.
  task automatic hold(input logic [5:0] sel, input logic [7:0] data, input int n);
    Scan_Sig = sel;
    SMG_Data = data;
    repeat (n) @(negedge CLK);
  endtask

  int fd_base;
  int ce_base;
  logic [23:0] exp_data;
  logic [5:0]  exp_valid;

  initial begin
    RST_N    = 1'b0;
    Scan_Sig = 6'h3f;
    SMG_Data = 8'hff;
    repeat (3) @(negedge CLK);

    // Reset state.
    check("rst_data",  32'(Digit_Data),  32'h0);
    check("rst_valid", 32'(Digit_Valid), 32'h0);
    check("rst_dp",    32'(Dp_Flags),    32'h0);
    check("rst_fd",    32'(Frame_Done),  32'h0);
    check("rst_ce",    32'(Code_Err),    32'h0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Digit 0 = 2. First edge after driving is edge n; capture lands on
    // edge n+S+1, so after n+S nothing has changed yet.
    hold(6'h3e, 8'ha4, S + 1);
    check("lat_early_valid", 32'(Digit_Valid), 32'h0);
    @(negedge CLK);
    check("lat_data0",  32'(Digit_Data[3:0]), 32'h2);
    check("lat_valid0", 32'(Digit_Valid[0]),  32'h1);
    check("lat_dp0",    32'(Dp_Flags[0]),     32'h0);
    repeat (2) @(negedge CLK);

    // Full frame: digit 0 is a recapture, so the pulse comes only with digit 5.
    fd_base = fd_count;
    hold(6'h3e, 8'hc0, 20);
    hold(6'h3d, 8'hf9, 20);
    hold(6'h3b, 8'ha4, 20);
    hold(6'h37, 8'hb0, 20);
    hold(6'h2f, 8'h99, 20);
    check("frame_no_early_fd", 32'(fd_count - fd_base), 32'd0);
    hold(6'h1f, 8'h92, 20);
    check("frame_fd_once", 32'(fd_count - fd_base), 32'd1);
    check("frame_data",    32'(Digit_Data),  32'h543210);
    check("frame_valid",   32'(Digit_Valid), 32'h3f);
    check("frame_dp",      32'(Dp_Flags),    32'h00);

    // Pattern 88 on digit 2: hex build decodes A, otherwise an error capture.
    fd_base = fd_count;
    ce_base = ce_count;
    hold(6'h3b, 8'h88, 20);
`ifdef SMG_HEX_DECODE_EN
    exp_data  = 24'h543a10;
    exp_valid = 6'h3f;
    check("hex_ce", 32'(ce_count - ce_base), 32'd0);
`else
    exp_data  = 24'h543210;
    exp_valid = 6'h3b;
    check("hex_ce", 32'(ce_count - ce_base), 32'd1);
`endif
    check("hex_data",  32'(Digit_Data),  32'(exp_data));
    check("hex_valid", 32'(Digit_Valid), 32'(exp_valid));
    check("hex_dp",    32'(Dp_Flags),    32'h00);
    check("hex_no_fd", 32'(fd_count - fd_base), 32'd0);

    // Digit 1 with a segment bus that never settles long enough.
    hold(6'h3d, 8'hf9, 8);
    hold(6'h3d, 8'hc0, 8);
    hold(6'h3d, 8'hf9, 8);
    hold(6'h3d, 8'hc0, 8);
    check("unstable_data", 32'(Digit_Data), 32'(exp_data));
    // 8'h10: segments spell 9 and the decimal point is lit.
    exp_data[7:4] = 4'h9;
    exp_valid[1]  = 1'b1;
    hold(6'h3d, 8'h10, 20);
    check("dp_data",  32'(Digit_Data),  32'(exp_data));
    check("dp_flags", 32'(Dp_Flags),    32'h02);
    check("dp_valid", 32'(Digit_Valid), 32'(exp_valid));

    // Two selects low, then all high: blanking, nothing happens.
    fd_base = fd_count;
    ce_base = ce_count;
    hold(6'h3c, 8'h99, 40);
    hold(6'h3f, 8'h82, 20);
    check("blank_data", 32'(Digit_Data), 32'(exp_data));
    check("blank_ce",   32'(ce_count - ce_base), 32'd0);
    check("blank_fd",   32'(fd_count - fd_base), 32'd0);

    // Reset in the middle of a TRACK on digit 3 (counter = 10 after edge n+11).
    hold(6'h37, 8'h80, 12);
    RST_N = 1'b0;
    #1;
    check("mid_rst_data",  32'(Digit_Data),  32'h0);
    check("mid_rst_valid", 32'(Digit_Valid), 32'h0);
    check("mid_rst_dp",    32'(Dp_Flags),    32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (S + 1) @(negedge CLK);
    check("rerun_early_valid", 32'(Digit_Valid), 32'h0);
    @(negedge CLK);
    check("rerun_data",  32'(Digit_Data),  32'h008000);
    check("rerun_valid", 32'(Digit_Valid), 32'h08);
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
